cpkt_cell_arb: RTL and testbench

- Round-robin scheduler that shares one cell-gathering datapath (CELL_GAP beats of DWID folded into one wide cell) between NSRC requesters in the TCP RX path.
- The gatherer has no backpressure: once its first beat arrives, it counts through the remaining beats regardless of input.
- This block therefore grants one requester at a time for exactly CELL_GAP consecutive beats and never interleaves sources inside a cell.
- Output is a registered beat stream with source id and sop/eop tags, aligned with the beats it feeds to the gatherer.

---
 rtl/cpkt_cell_arb.sv | 137 +++++++++++++
 tb/tb_cpkt_cell_arb.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/cpkt_cell_arb.sv
`default_nettype none
// ============================================================================
// Module   : cpkt_cell_arb
// Purpose  : Round-robin cell scheduler in the TCP RX path. Several requesters
//            share one cell gatherer that has no backpressure. A grant
//            therefore lasts exactly CELL_GAP beats and is never interleaved
//            with another source. The selected beats are re-registered and
//            tagged with source id and sop/eop for the gatherer.
// Ports    : clk, rst            - clock, asynchronous active-high reset
//            i_arb_en            - global enable (blocks new grants only)
//            i_src_en            - per-source enable mask
//            i_src_cell_rdy      - source holds at least one whole cell
//            i_src_dat           - FWFT data, source i at [DWID*i +: DWID]
//            o_src_rd            - pop strobe per source
//            o_cpkt_vld/dat/sid  - registered beat to the gatherer
//            o_cpkt_sop/eop      - first / last beat of a cell
//            o_busy              - a grant is active
// Revision : 1.0 - initial release
// ============================================================================
module cpkt_cell_arb #(
  parameter int DWID     = 256,
  parameter int CELL_GAP = 4,
  parameter int NSRC     = 4,
  parameter int SID_W    = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_arb_en,
  input  logic [NSRC-1:0]      i_src_en,
  input  logic [NSRC-1:0]      i_src_cell_rdy,
  input  logic [NSRC*DWID-1:0] i_src_dat,
  output logic [NSRC-1:0]      o_src_rd,
  output logic                 o_cpkt_vld,
  output logic [DWID-1:0]      o_cpkt_dat,
  output logic [SID_W-1:0]     o_cpkt_sid,
  output logic                 o_cpkt_sop,
  output logic                 o_cpkt_eop,
  output logic                 o_busy
);

  localparam int C_CW = $clog2(CELL_GAP) + 1;

  // Grant state
  logic             r_gnt_vld;
  logic [SID_W-1:0] r_gnt_id;
  logic [C_CW-1:0]  r_bcnt;
  logic [SID_W-1:0] r_rr_ptr;

  logic [NSRC-1:0]  w_req;
  logic             w_dp;
  logic             w_last;
  logic             w_found;
  logic [SID_W-1:0] w_win;
  logic [SID_W-1:0] w_next_rr;
  logic [DWID-1:0]  w_sel_dat;
  int               v_idx;

  assign w_req  = i_arb_en ? (i_src_cell_rdy & i_src_en) : '0;
  assign w_last = (r_bcnt == C_CW'(CELL_GAP - 1));
  // Decision point: idle, or on the last beat of the current cell so the
  // next grant follows the eop beat with no bubble.
  assign w_dp   = !r_gnt_vld || w_last;

  // Round-robin search starting at r_rr_ptr, wrapping modulo NSRC.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    v_idx   = 0;
    for (int k = 0; k < NSRC; k++) begin
      v_idx = (int'(r_rr_ptr) + k) % NSRC;
      if (!w_found && w_req[v_idx]) begin
        w_found = 1'b1;
        w_win   = SID_W'(v_idx);
      end
    end
  end

  assign w_next_rr = (int'(w_win) == NSRC - 1) ? '0 : w_win + SID_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_gnt_vld <= 1'b0;
      r_gnt_id  <= '0;
      r_bcnt    <= '0;
      r_rr_ptr  <= '0;
    end else if (w_dp) begin
      if (w_found) begin
        r_gnt_vld <= 1'b1;
        r_gnt_id  <= w_win;
        r_bcnt    <= '0;
        r_rr_ptr  <= w_next_rr;
      end else begin
        r_gnt_vld <= 1'b0;
      end
    end else begin
      // Mid-burst: enables and requests are ignored so the cell completes.
      r_bcnt <= r_bcnt + C_CW'(1);
    end
  end

  // Pop strobes are decoded straight from the grant registers.
  for (genvar gi = 0; gi < NSRC; gi++) begin : g_rd
    assign o_src_rd[gi] = r_gnt_vld && (r_gnt_id == SID_W'(gi));
  end

  always_comb begin
    w_sel_dat = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (r_gnt_id == SID_W'(i)) begin
        w_sel_dat = i_src_dat[i*DWID +: DWID];
      end
    end
  end

  assign o_busy = r_gnt_vld;

  // One-cycle output pipeline aligned with the popped beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_cpkt_vld <= 1'b0;
      o_cpkt_dat <= '0;
      o_cpkt_sid <= '0;
      o_cpkt_sop <= 1'b0;
      o_cpkt_eop <= 1'b0;
    end else begin
      o_cpkt_vld <= |o_src_rd;
      if (|o_src_rd) begin
        o_cpkt_dat <= w_sel_dat;
      end
      o_cpkt_sid <= r_gnt_id;
      o_cpkt_sop <= r_gnt_vld && (r_bcnt == '0);
      o_cpkt_eop <= r_gnt_vld && w_last;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cpkt_cell_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpkt_cell_arb
// Purpose  : Directed testbench for cpkt_cell_arb. Instance A uses
//            CELL_GAP=4, instance B uses CELL_GAP=1; both use DWID=16.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cpkt_cell_arb;

  localparam int C_DW = 16;
  localparam int C_NS = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Instance A (CELL_GAP=4)
  logic              a_arb_en;
  logic [C_NS-1:0]   a_src_en;
  logic [C_NS-1:0]   a_rdy;
  logic [C_NS*C_DW-1:0] a_dat;
  logic [C_NS-1:0]   a_rd;
  logic              a_vld, a_sop, a_eop, a_busy;
  logic [C_DW-1:0]   a_odat;
  logic [1:0]        a_sid;

  // Instance B (CELL_GAP=1)
  logic [C_NS-1:0]   b_rdy;
  logic [C_NS*C_DW-1:0] b_dat;
  logic [C_NS-1:0]   b_rd;
  logic              b_vld, b_sop, b_eop, b_busy;
  logic [C_DW-1:0]   b_odat;
  logic [1:0]        b_sid;

  // FWFT source model for A: source i presents 0x00A0 + 0x100*i + popped count.
  logic [7:0] a_ptr [C_NS];
  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < C_NS; i++) begin
      if (rst) a_ptr[i] <= '0;
      else if (a_rd[i]) a_ptr[i] <= a_ptr[i] + 8'd1;
    end
  end
  for (genvar gi = 0; gi < C_NS; gi++) begin : g_adat
    assign a_dat[gi*C_DW +: C_DW] = 16'h00A0 + 16'(gi) * 16'h0100 + 16'(a_ptr[gi]);
    assign b_dat[gi*C_DW +: C_DW] = 16'(gi) * 16'h0100;
  end

  cpkt_cell_arb #(.DWID(C_DW), .CELL_GAP(4), .NSRC(C_NS), .SID_W(2)) u_dut_a (
    .clk(clk), .rst(rst), .i_arb_en(a_arb_en), .i_src_en(a_src_en),
    .i_src_cell_rdy(a_rdy), .i_src_dat(a_dat), .o_src_rd(a_rd),
    .o_cpkt_vld(a_vld), .o_cpkt_dat(a_odat), .o_cpkt_sid(a_sid),
    .o_cpkt_sop(a_sop), .o_cpkt_eop(a_eop), .o_busy(a_busy));

  cpkt_cell_arb #(.DWID(C_DW), .CELL_GAP(1), .NSRC(C_NS), .SID_W(2)) u_dut_b (
    .clk(clk), .rst(rst), .i_arb_en(1'b1), .i_src_en(4'b1111),
    .i_src_cell_rdy(b_rdy), .i_src_dat(b_dat), .o_src_rd(b_rd),
    .o_cpkt_vld(b_vld), .o_cpkt_dat(b_odat), .o_cpkt_sid(b_sid),
    .o_cpkt_sop(b_sop), .o_cpkt_eop(b_eop), .o_busy(b_busy));

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  int beats;
  int id;
  int k;

  initial begin
    a_arb_en = 1'b1;
    a_src_en = 4'b1111;
    a_rdy    = '0;
    b_rdy    = '0;

    // Reset state
    step();
    chk("rst_rd",   32'(a_rd), 0);
    chk("rst_vld",  32'(a_vld), 0);
    chk("rst_busy", 32'(a_busy), 0);
    chk("rst_misc", {a_odat, 6'd0, a_sid, 6'd0, a_sop, a_eop}, 0);
    step();
    rst = 1'b0;

    // Test 1: single source 0, one cell 0xA0..0xA3
    a_rdy = 4'b0001;
    step();
    chk("t1_rd0",  32'(a_rd), 32'h1);
    chk("t1_vld0", 32'(a_vld), 0);
    chk("t1_busy", 32'(a_busy), 1);
    a_rdy = 4'b0000;
    for (int b = 0; b < 4; b++) begin
      step();
      chk("t1_rd",  32'(a_rd), (b < 3) ? 32'h1 : 32'h0);
      chk("t1_vld", 32'(a_vld), 1);
      chk("t1_dat", 32'(a_odat), 32'h00A0 + 32'(b));
      chk("t1_sid", 32'(a_sid), 0);
      chk("t1_sop", 32'(a_sop), (b == 0) ? 1 : 0);
      chk("t1_eop", 32'(a_eop), (b == 3) ? 1 : 0);
    end
    step();
    chk("t1_vld_end", 32'(a_vld), 0);

    // Test 2: all four ready, rotation 0,1,2,3,0 with no gaps
    do_reset();
    a_rdy = 4'b1111;
    for (int t = 1; t <= 20; t++) begin
      step();
      id = ((t - 1) / 4) % 4;
      chk("t2_rd", 32'(a_rd), 32'(1) << id);
      if (t >= 2) begin
        k = t - 2;
        chk("t2_vld", 32'(a_vld), 1);
        chk("t2_sid", 32'(a_sid), 32'((k / 4) % 4));
        chk("t2_sop", 32'(a_sop), (k % 4 == 0) ? 1 : 0);
        chk("t2_eop", 32'(a_eop), (k % 4 == 3) ? 1 : 0);
        chk("t2_dat", 32'(a_odat),
            32'h00A0 + 32'h100 * 32'((k / 4) % 4) + 32'(4 * (k / 16) + k % 4));
      end
    end
    a_rdy = 4'b0000;

    // Test 3: source 2, arb_en dropped one cycle into the burst
    do_reset();
    a_rdy = 4'b0100;
    beats = 0;
    step();
    chk("t3_rd_first", 32'(a_rd), 32'h4);
    a_arb_en = 1'b0;
    for (int t = 0; t < 3; t++) begin
      step();
      if (a_vld) beats++;
      chk("t3_rd_hold", 32'(a_rd), 32'h4);
    end
    for (int t = 0; t < 3; t++) begin
      step();
      if (a_vld) beats++;
      chk("t3_rd_idle", 32'(a_rd), 0);
      chk("t3_busy_idle", 32'(a_busy), 0);
    end
    chk("t3_beats", 32'(beats), 4);
    a_arb_en = 1'b1;
    step();
    chk("t3_regrant", 32'(a_rd), 32'h4);
    a_rdy = 4'b0000;

    // Test 4: CELL_GAP=1, sources 1 and 3 alternate every cycle
    do_reset();
    b_rdy = 4'b1010;
    for (int t = 1; t <= 6; t++) begin
      step();
      chk("t4_rd", 32'(b_rd), (t % 2 == 1) ? 32'h2 : 32'h8);
      if (t >= 2) begin
        chk("t4_sid", 32'(b_sid), (t % 2 == 0) ? 1 : 3);
        chk("t4_dat", 32'(b_odat), (t % 2 == 0) ? 32'h100 : 32'h300);
        chk("t4_sopeop", {30'd0, b_sop, b_eop}, 32'h3);
      end
    end
    b_rdy = 4'b0000;

    // Test 5: reset on beat 2 of a cell, then restart from source 0
    do_reset();
    a_rdy = 4'b1111;
    step();
    step();
    step();
    chk("t5_pre_rd", 32'(a_rd), 32'h1);
    rst = 1'b1;
    #1;
    chk("t5_rd",   32'(a_rd), 0);
    chk("t5_vld",  32'(a_vld), 0);
    chk("t5_busy", 32'(a_busy), 0);
    step();
    rst = 1'b0;
    step();
    chk("t5_restart", 32'(a_rd), 32'h1);

    // Test 6: src_en=1110, rotation 1,2,3,1 and source 0 never granted
    do_reset();
    a_src_en = 4'b1110;
    for (int t = 1; t <= 16; t++) begin
      step();
      id = ((t - 1) / 4) % 3 + 1;
      chk("t6_rd", 32'(a_rd), 32'(1) << id);
    end
    a_rdy = 4'b0000;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
